// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared constants and helpers for the async FIFO and its read-side packer.
//   DSIZE_DEF  : default FIFO word width
//   ASIZE_DEF  : default FIFO address width (used by the FIFO top)
//   RATIO_DEF  : default number of words packed into one output beat
//   LANE_FIRST : lane that receives the first-popped word of a beat
//   clog2()    : ceil(log2(value)) usable in localparam expressions
// -----------------------------------------------------------------------------
package afifo_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int ASIZE_DEF  = 4;
  localparam int RATIO_DEF  = 4;

  localparam int LANE_FIRST = 0;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/afifo_out_slice.sv
// -----------------------------------------------------------------------------
// afifo_out_slice
// Single-entry valid/ready output register.
//
// Handshake: a beat is transferred on every rising clock edge where
// out_valid && out_ready. Once out_valid is high it stays high and out_data
// (and out_keep) stay stable until that transfer happens. load may be asserted
// only when slot_free is high; slot_free = !out_valid || out_ready, so a new
// beat can be loaded in the same cycle the current one is accepted.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_data into the slot this cycle
//   load_data    : beat to capture
//   out_ready    : downstream accept
//   slot_free    : slot can take a beat this cycle
//   out_valid    : slot holds a beat
//   out_data     : held beat
//   load_keep / out_keep : lane mask, only with RD_PACK_FLUSH_EN defined
// -----------------------------------------------------------------------------
module afifo_out_slice #(
  parameter int W  = 32
`ifdef RD_PACK_FLUSH_EN
  , parameter int KW = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          out_ready,
  output logic          slot_free,
  output logic          out_valid,
  output logic [W-1:0]  out_data
`ifdef RD_PACK_FLUSH_EN
  , input  logic [KW-1:0] load_keep
  , output logic [KW-1:0] out_keep
`endif
);

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
`ifdef RD_PACK_FLUSH_EN
  logic [KW-1:0] keep_q,  keep_d;
`endif

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef RD_PACK_FLUSH_EN
    keep_d  = keep_q;
`endif
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
`ifdef RD_PACK_FLUSH_EN
      keep_d  = load_keep;
`endif
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef RD_PACK_FLUSH_EN
      keep_q  <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef RD_PACK_FLUSH_EN
      keep_q  <= keep_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
`ifdef RD_PACK_FLUSH_EN
  assign out_keep  = keep_q;
`endif

endmodule

// File: rtl/afifo_rd_pack.sv
// -----------------------------------------------------------------------------
// afifo_rd_pack
// Read-side consumer of the async FIFO (rclk domain only). Pops DSIZE-bit
// words and packs RATIO of them into one RATIO*DSIZE-bit beat on a
// valid/ready stream. The first-popped word lands in bits [DSIZE-1:0].
//
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   rempty       : FIFO empty flag
//   rdata        : FIFO head word (combinational read), valid when !rempty
//   rinc         : FIFO pop strobe
//   out_valid / out_ready / out_data : packed beat stream
//   out_keep, flush : only with RD_PACK_FLUSH_EN defined. flush closes a
//                  partial beat (unfilled lanes zero); out_keep marks the
//                  filled lanes.
//
// Optional feature macro: RD_PACK_FLUSH_EN
// -----------------------------------------------------------------------------
module afifo_rd_pack
  import afifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int RATIO = RATIO_DEF
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RATIO*DSIZE-1:0] out_data
`ifdef RD_PACK_FLUSH_EN
  , output logic [RATIO-1:0]     out_keep
  , input  logic                 flush
`endif
);

  localparam int            CW         = clog2(RATIO + 1);
  localparam int            BW         = RATIO * DSIZE;
  localparam logic [CW-1:0] COUNT_FULL = CW'(RATIO);

  logic [BW-1:0] asm_q,   asm_d;
  logic [CW-1:0] count_q, count_d;

  logic slot_free;
  logic full;
  logic full_xfer;
  logic flush_xfer;
  logic xfer;
  logic pop;

  // Transfer and pop decisions. A full beat that moves to the slot frees the
  // assembly register in the same cycle, so a pop may ride along into lane 0.
  // A flush-transfer never pops: the partial beat leaves alone.
  always_comb begin
    full      = (count_q == COUNT_FULL);
    full_xfer = full && slot_free;
`ifdef RD_PACK_FLUSH_EN
    flush_xfer = flush && (count_q != '0) && !full && slot_free;
`else
    flush_xfer = 1'b0;
`endif
    xfer = full_xfer || flush_xfer;
    // rrst_n gating keeps rinc low while reset is held.
    pop  = rrst_n && !rempty && ((!full && !flush_xfer) || full_xfer);
  end

  assign rinc = pop;

  // Assembly register. Lanes are cleared on transfer so a flushed partial
  // beat carries zeros in its unfilled lanes.
  always_comb begin
    asm_d   = asm_q;
    count_d = count_q;
    if (xfer) begin
      asm_d   = '0;
      count_d = '0;
    end
    if (pop) begin
      if (xfer) begin
        asm_d[LANE_FIRST*DSIZE +: DSIZE] = rdata;
        count_d                          = CW'(1);
      end else begin
        for (int i = 0; i < RATIO; i++) begin
          if (count_q == CW'(i)) begin
            asm_d[i*DSIZE +: DSIZE] = rdata;
          end
        end
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      asm_q   <= '0;
      count_q <= '0;
    end else begin
      asm_q   <= asm_d;
      count_q <= count_d;
    end
  end

`ifdef RD_PACK_FLUSH_EN
  // Lane i is valid when it has been written, i.e. i < count.
  logic [RATIO-1:0] keep;
  always_comb begin
    keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      keep[i] = (CW'(i) < count_q);
    end
  end
`endif

  afifo_out_slice #(
    .W  (BW)
`ifdef RD_PACK_FLUSH_EN
    , .KW (RATIO)
`endif
  ) u_out_slice (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .load      (xfer),
    .load_data (asm_q),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef RD_PACK_FLUSH_EN
    , .load_keep (keep)
    , .out_keep  (out_keep)
`endif
  );

endmodule

// File: tb/tb_afifo_rd_pack.sv
// -----------------------------------------------------------------------------
// tb_afifo_rd_pack
// Bench for afifo_rd_pack with DSIZE=8, RATIO=4. A queue models the FIFO
// (rempty/rdata/rinc); expected beats go into exp_q when words are issued and
// a negedge monitor pops and compares on every out_valid && out_ready.
// -----------------------------------------------------------------------------
module tb_afifo_rd_pack;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int BW    = DSIZE * RATIO;

  // ---------------- clock / reset ----------------
  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_data;
`ifdef RD_PACK_FLUSH_EN
  logic [RATIO-1:0] out_keep;
  logic             flush;
`endif

  always #5 rclk = ~rclk;

  afifo_rd_pack #(
    .DSIZE (DSIZE),
    .RATIO (RATIO)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RD_PACK_FLUSH_EN
    , .out_keep (out_keep)
    , .flush    (flush)
`endif
  );

  // ---------------- bookkeeping ----------------
  int               checks = 0;
  int               errors = 0;
  logic [BW-1:0]    exp_q[$];
  logic [RATIO-1:0] exp_keep_q[$];
  logic [DSIZE-1:0] fifo_q[$];
  logic             gate_empty = 1'b0;
  int               cyc = 0;
  int               pop_edges[$];
  int               hs_cycles[$];
  int               valid_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  // Pops on edges where rinc is high; outputs settle at +3, before the next
  // negedge, and pick up pushes made at the +2 drive point.
  always @(posedge rclk) begin
    logic popped;
    cyc    = cyc + 1;
    popped = rinc;
    if (popped) pop_edges.push_back(cyc);
    #1;
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #2;
    rempty = gate_empty || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // ---------------- monitor / scoreboard ----------------
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_data = '0;

  always @(negedge rclk) begin
    logic [BW-1:0]    e;
    logic [RATIO-1:0] ek;
    check("rinc_while_empty", rinc && rempty, 0);
    if (out_valid) valid_cycles++;
    if (prev_hold && rrst_n) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    if (out_valid && out_ready && rrst_n) begin
      hs_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=0x%0h expected=none", out_data);
      end else begin
        e  = exp_q.pop_front();
        ek = exp_keep_q.pop_front();
        check("beat_data", out_data, e);
`ifdef RD_PACK_FLUSH_EN
        check("beat_keep", out_keep, ek);
`endif
      end
    end
    prev_hold = out_valid && !out_ready && rrst_n;
    prev_data = out_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic expect_beat(input logic [BW-1:0] b, input logic [RATIO-1:0] k);
    exp_q.push_back(b);
    exp_keep_q.push_back(k);
  endtask

  task automatic clear_stats();
    pop_edges.delete();
    hs_cycles.delete();
    valid_cycles = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int d0;
    int d1;
    rrst_n    = 1'b0;
    out_ready = 1'b1;
`ifdef RD_PACK_FLUSH_EN
    flush     = 1'b0;
`endif
    tick(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rinc", rinc, 0);
    rrst_n = 1'b1;
    tick(2);

    // T1: one beat, latency and single-cycle valid
    clear_stats();
    expect_beat(32'h44332211, 4'hF);
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    tick(10);
    check("t1_pops", pop_edges.size(), 4);
    check("t1_beats", hs_cycles.size(), 1);
    check("t1_valid_cycles", valid_cycles, 1);
    lat = (pop_edges.size() == 4 && hs_cycles.size() == 1) ? hs_cycles[0] - pop_edges[3] : -1;
    check("t1_latency", lat, 1);

    // T2: 12 words back-to-back, beats every 4 cycles
    clear_stats();
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    expect_beat(32'h0C0B0A09, 4'hF);
    for (int i = 1; i <= 12; i++) push_word(DSIZE'(i));
    tick(20);
    check("t2_pops", pop_edges.size(), 12);
    lat = (pop_edges.size() == 12) ? pop_edges[11] - pop_edges[0] : -1;
    check("t2_pop_span", lat, 11);
    check("t2_beats", hs_cycles.size(), 3);
    d0 = (hs_cycles.size() == 3) ? hs_cycles[1] - hs_cycles[0] : -1;
    d1 = (hs_cycles.size() == 3) ? hs_cycles[2] - hs_cycles[1] : -1;
    check("t2_spacing0", d0, 4);
    check("t2_spacing1", d1, 4);

    // T3: backpressure with 8 words queued
    clear_stats();
    out_ready = 1'b0;
    expect_beat(32'h34333231, 4'hF);
    expect_beat(32'h38373635, 4'hF);
    for (int i = 0; i < 8; i++) push_word(8'h31 + DSIZE'(i));
    tick(15);
    check("t3_pops", pop_edges.size(), 8);
    check("t3_valid", out_valid, 1);
    check("t3_data_held", out_data, 32'h34333231);
    check("t3_rinc_stalled", rinc, 0);
    out_ready = 1'b1;
    tick(6);
    check("t3_beats", hs_cycles.size(), 2);
    drain("t3_drain");

    // T4: rempty toggling every cycle
    clear_stats();
    expect_beat(32'h8D7C6B5A, 4'hF);
    push_word(8'h5A); push_word(8'h6B); push_word(8'h7C); push_word(8'h8D);
    for (int i = 0; i < 12; i++) begin
      gate_empty = ~gate_empty;
      tick(1);
    end
    gate_empty = 1'b0;
    tick(4);
    check("t4_pops", pop_edges.size(), 4);
    d0 = (pop_edges.size() >= 2) ? pop_edges[1] - pop_edges[0] : -1;
    check("t4_pop_gap", d0, 2);
    check("t4_beats", hs_cycles.size(), 1);

    // T5: reset after two pops, then a fresh beat
    clear_stats();
    push_word(8'hE1); push_word(8'hE2);
    tick(4);
    check("t5_pre_pops", pop_edges.size(), 2);
    rrst_n = 1'b0;
    push_word(8'h99);
    #2;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_rempty", rempty, 0);
    check("t5_rst_rinc", rinc, 0);
    tick(2);
    check("t5_rst_pops", pop_edges.size(), 2);
    fifo_q.delete();
    tick(1);
    rrst_n = 1'b1;
    tick(2);
    expect_beat(32'hF4F3F2F1, 4'hF);
    push_word(8'hF1); push_word(8'hF2); push_word(8'hF3); push_word(8'hF4);
    tick(10);
    check("t5_beats", hs_cycles.size(), 1);

`ifdef RD_PACK_FLUSH_EN
    // T6: flush a two-word partial beat; second flush cycle sees count=0
    clear_stats();
    expect_beat(32'h0000BBAA, 4'b0011);
    push_word(8'hAA); push_word(8'hBB);
    tick(4);
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    tick(4);
    check("t6_pops", pop_edges.size(), 2);
    check("t6_beats", hs_cycles.size(), 1);
`endif

    drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
